mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single external data-memory port between two requesters: the CPU data port and a DMA/video requester.
- Sits between the CPU top level (its ReadMem/WriteMem/ExternalAddr/ExternalWriteData/ExternalReadData signals) and the memory.
- Grants one access at a time and tracks the memory's fixed read latency.
- Drives a stall back to the CPU pipeline and a grant/valid handshake to DMA. A starvation counter bounds DMA wait time.

Parameters:
- AW, 16, address width
- DW, 16, data width
- RD_LAT, 1, memory read latency in cycles, legal range 1..4
- STARVE_MAX, 8, cycles DMA may wait with dma_req high before it gets forced priority

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cpu_read  in  1  CPU load request (ReadMem)
- cpu_write  in  1  CPU store request (WriteMem)
- cpu_addr  in  AW  CPU address (ExternalAddr)
- cpu_wdata  in  DW  CPU store data
- cpu_rdata  out  DW  CPU load data, valid when cpu_rvalid=1
- cpu_rvalid  out  1  CPU load data valid, one cycle
- cpu_stall  out  1  CPU pipeline hold request
- dma_req  in  1  DMA request; held with its fields until granted
- dma_we  in  1  DMA write (1) or read (0)
- dma_addr  in  AW  DMA address
- dma_wdata  in  DW  DMA write data
- dma_gnt  out  1  one-cycle pulse; DMA request accepted this cycle
- dma_rdata  out  DW  DMA read data
- dma_rvalid  out  1  DMA read data valid, one cycle
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_we  out  1  memory write strobe
- mem_re  out  1  memory read strobe
- mem_rdata  in  DW  memory read data, valid RD_LAT cycles after mem_re

Behaviour:
- Clock is clk; reset is synchronous, active-high, on rst.
- Reset values: every output 0; state IDLE; lat_cnt=0; starve_cnt=0; owner=CPU.
- States:
  - IDLE: memory free.
  - RD_WAIT: read outstanding; lat_cnt counts down from RD_LAT.
- A write completes in its issue cycle and needs no wait state.
- Arbitration runs each cycle in IDLE, and in the final RD_WAIT cycle (lat_cnt==1) so back-to-back issue is possible:
  - cpu_req = cpu_read|cpu_write.
  - DMA wins if dma_req && (!cpu_req || starve_cnt>=STARVE_MAX). Otherwise CPU wins if cpu_req.
  - cpu_read and cpu_write both high: treated as a write.
- Issue, winner's fields driven combinationally in the issue cycle:
  - Read: mem_re=1, owner latched, go to RD_WAIT with lat_cnt=RD_LAT.
  - Write: mem_we=1, stay in (or return to) IDLE.
  - DMA issue pulses dma_gnt in the same cycle.
- Return: in the cycle lat_cnt reaches 1, mem_rdata routes to the owner's rdata and the owner's rvalid pulses.
  - Neither rdata output changes except on that owner's rvalid.
- cpu_stall (combinational): 1 when cpu_req && !(CPU issued a write this cycle || cpu_rvalid this cycle).
  - With RD_LAT=1, an uncontended CPU load stalls exactly 1 cycle.
  - An uncontended CPU store does not stall.
- While cpu_stall=1 the CPU holds its request fields stable. The arbiter does not re-issue a CPU read that is already outstanding (owner==CPU in RD_WAIT).
- starve_cnt:
  - +1 each cycle dma_req=1 and dma_gnt=0, saturating at STARVE_MAX.
  - Cleared on dma_gnt, or when dma_req=0.
- Issued accesses are never aborted. rst during RD_WAIT drops the read: no rvalid is produced and no strobe is issued in the reset cycle.
- mem_we and mem_re are never high together.

Decomposition:
- Shared cpu_pkg holds:
  - arb_state_t enum: IDLE, RD_WAIT
  - owner_t enum: OWN_CPU, OWN_DMA
  - AW/DW defaults
- One natural sub-module, arb_latency_tracker: lat_cnt and owner register, producing a done pulse and owner.
- Priority logic and starvation counter stay in the top.

Test Plan:
- CPU store alone, addr 0x0040, data 0xBEEF → same cycle: mem_we=1, mem_addr=0x0040, mem_wdata=0xBEEF, cpu_stall=0.
- CPU load alone with RD_LAT=1, memory returns 0x1234 → mem_re in cycle N, cpu_stall=1 in N, cpu_rvalid=1 with cpu_rdata=0x1234 in N+1, cpu_stall=0 in N+1.
- cpu_read and dma_req both asserted, starve_cnt=0 → CPU issued first. dma_gnt follows in the cycle the CPU read returns; dma_rvalid RD_LAT cycles later with the DMA data.
- CPU issues continuous stores with dma_req held, STARVE_MAX=8 → dma_gnt on the 9th cycle, cpu_stall=1 that cycle, CPU store issued the next cycle.
- DMA read outstanding (RD_LAT=3) when the CPU loads → cpu_stall held until the DMA data returns, CPU read issued in that same cycle, CPU data 3 cycles later. No rdata crossover between requesters.
- rst asserted while a read is in RD_WAIT → next cycle all outputs 0, no rvalid ever produced for the dropped read, new request issued normally after rst falls.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and defaults for the data-memory arbiter
package cpu_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

    typedef enum logic {
        IDLE,
        RD_WAIT
    } arb_state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_DMA
    } owner_t;

endpackage

// File: rtl/arb_latency_tracker.sv
// rtl/arb_latency_tracker.sv - counts down the memory read latency and remembers who owns the read
module arb_latency_tracker
    import cpu_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   start,
    input  owner_t start_owner,
    output logic   done,
    output owner_t owner
);

    localparam int LW = 3;

    logic [LW-1:0] lat_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt <= '0;
            owner   <= OWN_CPU;
        end else if (start) begin
            // A new issue may land on the return cycle of the previous read
            lat_cnt <= LW'(RD_LAT);
            owner   <= start_owner;
        end else if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
        end
    end

    assign done = (lat_cnt == LW'(1));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares the data-memory port between the CPU and a DMA requester
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_read,
    input  logic          cpu_write,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_t    state, state_nxt;
    logic [SW-1:0] starve_cnt;
    logic [DW-1:0] cpu_rdata_q, dma_rdata_q;
    logic          lat_done;
    owner_t        owner, issue_owner;
    logic          cpu_req, cpu_ok, arb_en, dma_win, cpu_win, rd_issue;

    arb_latency_tracker #(.RD_LAT(RD_LAT)) u_tracker (
        .clk         (clk),
        .rst         (rst),
        .start       (rd_issue),
        .start_owner (issue_owner),
        .done        (lat_done),
        .owner       (owner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        dma_gnt     = 1'b0;
        issue_owner = OWN_CPU;
        cpu_req     = cpu_read | cpu_write;
        arb_en      = (state == IDLE) || lat_done;
        // The CPU keeps its load asserted while stalled; never issue it twice
        cpu_ok      = cpu_req && !(state == RD_WAIT && owner == OWN_CPU);
        dma_win     = arb_en && dma_req && (!cpu_ok || starve_cnt >= SW'(STARVE_MAX));
        cpu_win     = arb_en && !dma_win && cpu_ok;
        cpu_rvalid  = lat_done && (owner == OWN_CPU);
        dma_rvalid  = lat_done && (owner == OWN_DMA);

        if (dma_win) begin
            mem_addr    = dma_addr;
            mem_wdata   = dma_we ? dma_wdata : '0;
            mem_we      = dma_we;
            mem_re      = !dma_we;
            dma_gnt     = 1'b1;
            issue_owner = OWN_DMA;
        end else if (cpu_win) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_write ? cpu_wdata : '0;
            mem_we    = cpu_write;
            mem_re    = !cpu_write;
        end

        cpu_stall = cpu_req && !((cpu_win && cpu_write) || cpu_rvalid);
        cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_q;
        dma_rdata = dma_rvalid ? mem_rdata : dma_rdata_q;

        if (mem_re) begin
            state_nxt = RD_WAIT;
        end else if (lat_done) begin
            state_nxt = IDLE;
        end

        // The reset cycle drops any outstanding read and issues nothing
        if (rst) begin
            mem_addr   = '0;
            mem_wdata  = '0;
            mem_we     = 1'b0;
            mem_re     = 1'b0;
            dma_gnt    = 1'b0;
            cpu_rvalid = 1'b0;
            dma_rvalid = 1'b0;
            cpu_stall  = 1'b0;
            cpu_rdata  = '0;
            dma_rdata  = '0;
        end
        rd_issue = mem_re;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
            if (dma_rvalid) dma_rdata_q <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !dma_req || dma_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt < SW'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter at read latencies 1 and 3
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        a_rst, a_cpu_read, a_cpu_write, a_dma_req, a_dma_we;
    logic [15:0] a_cpu_addr, a_cpu_wdata, a_dma_addr, a_dma_wdata;
    logic [15:0] a_cpu_rdata, a_dma_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        a_cpu_rvalid, a_cpu_stall, a_dma_gnt, a_dma_rvalid, a_mem_we, a_mem_re;

    logic        b_rst, b_cpu_read, b_cpu_write, b_dma_req, b_dma_we;
    logic [15:0] b_cpu_addr, b_cpu_wdata, b_dma_addr, b_dma_wdata;
    logic [15:0] b_cpu_rdata, b_dma_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_cpu_rvalid, b_cpu_stall, b_dma_gnt, b_dma_rvalid, b_mem_we, b_mem_re;

    mem_arbiter #(.AW(16), .DW(16), .RD_LAT(1), .STARVE_MAX(8)) u_a (
        .clk(clk), .rst(a_rst),
        .cpu_read(a_cpu_read), .cpu_write(a_cpu_write), .cpu_addr(a_cpu_addr),
        .cpu_wdata(a_cpu_wdata), .cpu_rdata(a_cpu_rdata), .cpu_rvalid(a_cpu_rvalid),
        .cpu_stall(a_cpu_stall), .dma_req(a_dma_req), .dma_we(a_dma_we),
        .dma_addr(a_dma_addr), .dma_wdata(a_dma_wdata), .dma_gnt(a_dma_gnt),
        .dma_rdata(a_dma_rdata), .dma_rvalid(a_dma_rvalid), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_we(a_mem_we), .mem_re(a_mem_re),
        .mem_rdata(a_mem_rdata)
    );

    mem_arbiter #(.AW(16), .DW(16), .RD_LAT(3), .STARVE_MAX(8)) u_b (
        .clk(clk), .rst(b_rst),
        .cpu_read(b_cpu_read), .cpu_write(b_cpu_write), .cpu_addr(b_cpu_addr),
        .cpu_wdata(b_cpu_wdata), .cpu_rdata(b_cpu_rdata), .cpu_rvalid(b_cpu_rvalid),
        .cpu_stall(b_cpu_stall), .dma_req(b_dma_req), .dma_we(b_dma_we),
        .dma_addr(b_dma_addr), .dma_wdata(b_dma_wdata), .dma_gnt(b_dma_gnt),
        .dma_rdata(b_dma_rdata), .dma_rvalid(b_dma_rvalid), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .mem_re(b_mem_re),
        .mem_rdata(b_mem_rdata)
    );

    function automatic logic [15:0] pat(input logic [7:0] a);
        if (a == 8'h80) return 16'h1234;
        return {a ^ 8'h5A, a};
    endfunction

    // Behavioural memories: fixed-latency read pipes, junk data when no read is in flight
    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];
    logic [15:0] a_pipe;
    logic [15:0] b_pipe [3];
    logic        a_loaded = 1'b0;
    logic        b_loaded = 1'b0;

    always @(posedge clk) begin
        if (!a_loaded) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= pat(8'(i));
            a_loaded <= 1'b1;
        end else if (a_mem_we) begin
            mem_a[a_mem_addr[7:0]] <= a_mem_wdata;
        end
        a_pipe <= a_mem_re ? mem_a[a_mem_addr[7:0]] : 16'($urandom);
    end
    assign a_mem_rdata = a_pipe;

    always @(posedge clk) begin
        if (!b_loaded) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= pat(8'(i));
            b_loaded <= 1'b1;
        end else if (b_mem_we) begin
            mem_b[b_mem_addr[7:0]] <= b_mem_wdata;
        end
        b_pipe[0] <= b_mem_re ? mem_b[b_mem_addr[7:0]] : 16'($urandom);
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign b_mem_rdata = b_pipe[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state for the randomized phase
    logic [15:0] shadow [256];
    logic        c_rd, c_wr, d_req, d_we, hold_c, hold_d;
    logic [15:0] c_addr, c_wd, d_addr, d_wd;
    bit          out_valid, out_dma;
    int          out_ret, starve, cyc, r;
    logic [15:0] out_data, exp_crd, exp_drd, e_addr, e_wd;
    bit          free_now, ret_c, ret_d, creq, cok, dwin, cwin;
    bit          e_re, e_we, e_stall;

    initial begin
        a_rst = 1'b1; a_cpu_read = 1'b0; a_cpu_write = 1'b1; a_cpu_addr = 16'h0033;
        a_cpu_wdata = 16'h7777; a_dma_req = 1'b1; a_dma_we = 1'b0; a_dma_addr = 16'h0;
        a_dma_wdata = 16'h0;
        b_rst = 1'b1; b_cpu_read = 1'b0; b_cpu_write = 1'b0; b_cpu_addr = 16'h0;
        b_cpu_wdata = 16'h0; b_dma_req = 1'b0; b_dma_we = 1'b0; b_dma_addr = 16'h0;
        b_dma_wdata = 16'h0;

        tick();
        tick();
        @(negedge clk);
        chk("rst_we", a_mem_we, 0);
        chk("rst_re", a_mem_re, 0);
        chk("rst_gnt", a_dma_gnt, 0);
        chk("rst_stall", a_cpu_stall, 0);
        chk("rst_addr", a_mem_addr, 0);

        tick();
        a_rst = 1'b0; b_rst = 1'b0; a_cpu_write = 1'b0; a_dma_req = 1'b0;
        @(negedge clk);
        chk("idle_rdata", a_cpu_rdata, 0);
        chk("idle_rvalid", a_cpu_rvalid, 0);
        chk("idle_drdata", a_dma_rdata, 0);
        chk("idle_b_re", b_mem_re, 0);

        // CPU store alone
        tick();
        a_cpu_write = 1'b1; a_cpu_addr = 16'h0040; a_cpu_wdata = 16'hBEEF;
        @(negedge clk);
        chk("st_we", a_mem_we, 1);
        chk("st_re", a_mem_re, 0);
        chk("st_addr", a_mem_addr, 16'h0040);
        chk("st_wdata", a_mem_wdata, 16'hBEEF);
        chk("st_stall", a_cpu_stall, 0);

        // CPU load alone, one-cycle latency
        tick();
        a_cpu_write = 1'b0; a_cpu_read = 1'b1; a_cpu_addr = 16'h0080;
        @(negedge clk);
        chk("ld_re", a_mem_re, 1);
        chk("ld_addr", a_mem_addr, 16'h0080);
        chk("ld_stall_n", a_cpu_stall, 1);
        chk("ld_rvalid_n", a_cpu_rvalid, 0);
        tick();
        @(negedge clk);
        chk("ld_rvalid", a_cpu_rvalid, 1);
        chk("ld_rdata", a_cpu_rdata, 16'h1234);
        chk("ld_stall_n1", a_cpu_stall, 0);
        chk("ld_no_reissue", a_mem_re, 0);
        tick();
        a_cpu_read = 1'b0;
        @(negedge clk);
        chk("ld_rvalid_off", a_cpu_rvalid, 0);
        chk("ld_rdata_hold", a_cpu_rdata, 16'h1234);

        // CPU and DMA read together: CPU first, DMA on the CPU return cycle
        tick();
        a_cpu_read = 1'b1; a_cpu_addr = 16'h0081;
        a_dma_req = 1'b1; a_dma_we = 1'b0; a_dma_addr = 16'h0082;
        @(negedge clk);
        chk("cd_re", a_mem_re, 1);
        chk("cd_addr", a_mem_addr, 16'h0081);
        chk("cd_gnt0", a_dma_gnt, 0);
        tick();
        @(negedge clk);
        chk("cd_crv", a_cpu_rvalid, 1);
        chk("cd_crd", a_cpu_rdata, pat(8'h81));
        chk("cd_gnt1", a_dma_gnt, 1);
        chk("cd_dre", a_mem_re, 1);
        chk("cd_daddr", a_mem_addr, 16'h0082);
        tick();
        a_cpu_read = 1'b0; a_dma_req = 1'b0;
        @(negedge clk);
        chk("cd_drv", a_dma_rvalid, 1);
        chk("cd_drd", a_dma_rdata, pat(8'h82));
        chk("cd_crd_hold", a_cpu_rdata, pat(8'h81));
        chk("cd_crv_off", a_cpu_rvalid, 0);

        // Continuous CPU stores against a waiting DMA write: DMA forced on the 9th cycle
        for (int i = 1; i <= 10; i++) begin
            tick();
            a_cpu_write = 1'b1;
            a_cpu_addr  = (i < 9) ? 16'(16'h00A0 + i) : 16'h00A9;
            a_cpu_wdata = (i < 9) ? 16'(16'h5000 + i) : 16'h5009;
            a_dma_req = (i <= 9); a_dma_we = 1'b1;
            a_dma_addr = 16'h0090; a_dma_wdata = 16'hD00D;
            @(negedge clk);
            chk($sformatf("sv_we_%0d", i), a_mem_we, 1);
            if (i == 9) begin
                chk("sv_gnt9", a_dma_gnt, 1);
                chk("sv_addr9", a_mem_addr, 16'h0090);
                chk("sv_wd9", a_mem_wdata, 16'hD00D);
                chk("sv_stall9", a_cpu_stall, 1);
            end else begin
                chk($sformatf("sv_gnt_%0d", i), a_dma_gnt, 0);
                chk($sformatf("sv_addr_%0d", i), a_mem_addr, a_cpu_addr);
                chk($sformatf("sv_stall_%0d", i), a_cpu_stall, 0);
            end
        end
        tick();
        a_cpu_write = 1'b0; a_dma_req = 1'b0;

        // DMA read outstanding (latency 3) when the CPU loads
        tick();
        b_dma_req = 1'b1; b_dma_we = 1'b0; b_dma_addr = 16'h0010;
        @(negedge clk);
        chk("dl_gnt", b_dma_gnt, 1);
        chk("dl_re", b_mem_re, 1);
        tick();
        b_dma_req = 1'b0; b_cpu_read = 1'b1; b_cpu_addr = 16'h0011;
        @(negedge clk);
        chk("dl_stall1", b_cpu_stall, 1);
        chk("dl_re1", b_mem_re, 0);
        tick();
        @(negedge clk);
        chk("dl_stall2", b_cpu_stall, 1);
        chk("dl_re2", b_mem_re, 0);
        tick();
        @(negedge clk);
        chk("dl_drv", b_dma_rvalid, 1);
        chk("dl_drd", b_dma_rdata, pat(8'h10));
        chk("dl_cre", b_mem_re, 1);
        chk("dl_caddr", b_mem_addr, 16'h0011);
        chk("dl_stall3", b_cpu_stall, 1);
        chk("dl_crv0", b_cpu_rvalid, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge clk);
            chk("dl_stall_w", b_cpu_stall, 1);
            chk("dl_crv_w", b_cpu_rvalid, 0);
            chk("dl_re_w", b_mem_re, 0);
        end
        tick();
        @(negedge clk);
        chk("dl_crv", b_cpu_rvalid, 1);
        chk("dl_crd", b_cpu_rdata, pat(8'h11));
        chk("dl_stall_end", b_cpu_stall, 0);
        chk("dl_drd_hold", b_dma_rdata, pat(8'h10));
        chk("dl_drv_off", b_dma_rvalid, 0);
        tick();
        b_cpu_read = 1'b0;

        // Reset while a read waits
        tick();
        b_cpu_read = 1'b1; b_cpu_addr = 16'h0022;
        @(negedge clk);
        chk("rr_re", b_mem_re, 1);
        tick();
        b_rst = 1'b1; b_cpu_read = 1'b0;
        @(negedge clk);
        chk("rr_re0", b_mem_re, 0);
        chk("rr_we0", b_mem_we, 0);
        chk("rr_stall0", b_cpu_stall, 0);
        chk("rr_crd0", b_cpu_rdata, 0);
        chk("rr_drd0", b_dma_rdata, 0);
        chk("rr_addr0", b_mem_addr, 0);
        tick();
        b_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rr_no_crv", b_cpu_rvalid, 0);
            chk("rr_no_drv", b_dma_rvalid, 0);
            chk("rr_crd", b_cpu_rdata, 0);
            tick();
        end
        b_cpu_read = 1'b1; b_cpu_addr = 16'h0023;
        @(negedge clk);
        chk("rr_new_re", b_mem_re, 1);
        chk("rr_new_addr", b_mem_addr, 16'h0023);
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge clk);
            chk("rr_new_stall", b_cpu_stall, 1);
        end
        tick();
        @(negedge clk);
        chk("rr_new_rv", b_cpu_rvalid, 1);
        chk("rr_new_rd", b_cpu_rdata, pat(8'h23));
        tick();
        b_cpu_read = 1'b0;

        // Randomized traffic on the latency-3 instance against the reference model
        for (int i = 0; i < 256; i++) shadow[i] = pat(8'(i));
        out_valid = 0; out_dma = 0; out_ret = 0; out_data = '0; starve = 0;
        exp_crd = pat(8'h23); exp_drd = '0;
        hold_c = 0; hold_d = 0; c_rd = 0; c_wr = 0; d_req = 0; d_we = 0;
        c_addr = '0; c_wd = '0; d_addr = '0; d_wd = '0;
        for (cyc = 0; cyc < 600; cyc++) begin
            tick();
            if (!hold_c) begin
                r = int'($urandom_range(0, 5));
                c_rd = (r == 2 || r == 3 || r == 5);
                c_wr = (r == 4 || r == 5);
                c_addr = 16'($urandom); c_wd = 16'($urandom);
            end
            if (!hold_d) begin
                d_req = ($urandom_range(0, 4) < 2);
                d_we = 1'($urandom_range(0, 1));
                d_addr = 16'($urandom); d_wd = 16'($urandom);
            end
            b_cpu_read = c_rd; b_cpu_write = c_wr; b_cpu_addr = c_addr; b_cpu_wdata = c_wd;
            b_dma_req = d_req; b_dma_we = d_we; b_dma_addr = d_addr; b_dma_wdata = d_wd;

            free_now = !out_valid || (out_ret == cyc);
            ret_c = out_valid && (out_ret == cyc) && !out_dma;
            ret_d = out_valid && (out_ret == cyc) && out_dma;
            creq = c_rd || c_wr;
            cok = creq && !(out_valid && !out_dma);
            dwin = free_now && d_req && (!cok || starve >= 8);
            cwin = free_now && !dwin && cok;
            e_we = (dwin && d_we) || (cwin && c_wr);
            e_re = (dwin && !d_we) || (cwin && !c_wr);
            e_addr = dwin ? d_addr : c_addr;
            e_wd = dwin ? d_wd : c_wd;
            e_stall = creq && !((cwin && c_wr) || ret_c);
            if (ret_c) exp_crd = out_data;
            if (ret_d) exp_drd = out_data;

            @(negedge clk);
            chk("rnd_re", b_mem_re, e_re);
            chk("rnd_we", b_mem_we, e_we);
            chk("rnd_gnt", b_dma_gnt, dwin);
            chk("rnd_stall", b_cpu_stall, e_stall);
            chk("rnd_crv", b_cpu_rvalid, ret_c);
            chk("rnd_drv", b_dma_rvalid, ret_d);
            chk("rnd_crd", b_cpu_rdata, exp_crd);
            chk("rnd_drd", b_dma_rdata, exp_drd);
            if (e_re || e_we) chk("rnd_addr", b_mem_addr, e_addr);
            if (e_we) chk("rnd_wd", b_mem_wdata, e_wd);

            if (ret_c || ret_d) out_valid = 0;
            if (e_re) begin
                out_valid = 1; out_dma = dwin; out_ret = cyc + 3;
                out_data = shadow[e_addr[7:0]];
            end
            if (e_we) shadow[e_addr[7:0]] = e_wd;
            if (dwin || !d_req) starve = 0;
            else if (starve < 8) starve++;
            hold_c = e_stall;
            hold_d = d_req && !dwin;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
